key_encoder_8_3: RTL and testbench
==================================

# key_encoder_8_3

Debounced 8-to-3 key encoder for the board's active-low push-button bank. It is the input-side counterpart of the 3-to-8 active-low digit-select decoder: eight active-low lines come in, and a 3-bit index with valid, press and release strobes goes out to the game control logic. Each line passes through a synchroniser and a per-line debouncer. A priority encoder then feeds a two-state press/release machine.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles needed to accept a level change. Minimum 2. The default is 10 ms at 100 MHz.
- CNT_W, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- keys_n  input  8  raw active-low buttons, asynchronous to clk; bit i low means key i is pressed.
- key_code  output  3  index of the lowest-numbered debounced pressed key.
- key_valid  output  1  level; high while at least one debounced key is pressed.
- key_press  output  1  one-cycle strobe; a new key_code has become valid.
- key_release  output  1  one-cycle strobe; all keys are released.
- key_multi  output  1  level; high while two or more debounced keys are pressed.

## Operation
- Reset values:
  - key_code = 3'd0; key_valid, key_press, key_release and key_multi = 0.
  - Synchroniser flops = 1, so every line reads as released.
  - Debounced states = released; counters = 0; FSM = IDLE.
- Synchroniser: two flops per line. The debouncer sees only the second flop.
- Debouncer, per line, with sampled value s and accepted state d:
  - If s == d, the counter clears.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 on an increment, d takes s and the counter clears.
  - Any single cycle with s == d restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never propagate.
- Encoder (combinational on d):
  - p[i] = ~d[i] (pressed).
  - enc = lowest i with p[i] set.
  - any = |p.
  - multi = popcount(p) >= 2.
- FSM states and transitions:
  - IDLE, any rises: go to HELD; key_code <= enc; key_press = 1.
  - HELD, any falls: go to IDLE; key_release = 1; key_code holds its last value.
  - HELD, any stays high and enc != key_code: stay in HELD; key_code <= enc; key_press = 1; no release strobe.
    - This covers a lower key being added, and the lowest key being released while others remain held.
  - HELD, enc == key_code: no strobe.
- Outputs:
  - key_valid = (state == HELD). It is registered together with the state.
  - key_multi is registered from multi.
- Simultaneous events:
  - Several lines accepted on the same cycle are encoded together: one press strobe with the lowest index.
  - All lines released on the same cycle produce a single release strobe.
- key_press and key_release are never high in the same cycle.
- Reset mid-debounce or while HELD: everything returns to reset values immediately. A key still held after reset deasserts is re-detected after a full debounce interval and produces a fresh key_press.

## Timing
- Latency from the first clk edge that samples the new keys_n level to the strobe is DEBOUNCE_CYCLES + 3 cycles:
  - 2 cycles of synchroniser.
  - DEBOUNCE_CYCLES cycles of qualification.
  - 1 cycle of output register.
- key_code, key_valid and key_multi update on the same edge as the corresponding strobe.
- Strobes last exactly one cycle. key_code is stable for the whole cycle in which key_press is high.
- Release has the same latency as press.

## Structure
- Shared package key_pkg holds:
  - typedef for the FSM states, S_IDLE and S_HELD.
  - KEY_COUNT = 8 and KEY_CODE_W = 3, also used by the display decoder side.
- Sub-module debounce_line: one line's synchroniser, counter and accepted state. Parameters DEBOUNCE_CYCLES and CNT_W; ports clk, rst, raw_n, stable_n. The top instantiates it 8 times in a generate loop.
- The top holds the encoder, popcount and FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and CNT_W = 3.
- Reset: keys_n = 8'hFF, pulse rst → all outputs 0, key_code = 0; no strobe over the following 20 cycles.
- Clean press and release of key 5 (keys_n = 8'hDF), held 20 cycles:
  - key_press with key_code = 5 exactly 7 cycles after the first sampling edge; key_valid = 1.
  - After restoring 8'hFF: key_release 7 cycles later; key_valid = 0; key_code stays 5.
- Bounce: key 2 toggles every 2 cycles for 12 cycles, then stays low → no strobe during bouncing; a single key_press with key_code = 2, 7 cycles after the final stable edge.
- Overlap:
  - Key 6 held, then key 1 added → second key_press with code 1, key_multi = 1.
  - Release key 1 → key_press with code 6, key_multi = 0, no key_release.
  - Release key 6 → a single key_release.
- Simultaneous: keys 3 and 7 pressed on the same cycle (8'h77) → one key_press with code 3, key_multi = 1; both released together → one key_release.
- Reset mid-operation: key 4 held, rst asserted for 3 cycles while HELD → outputs 0 asynchronously. After rst deasserts with key 4 still low, a fresh key_press with code 4 follows DEBOUNCE_CYCLES + 3 cycles later.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: definitions shared by the key encoder and the display decoder side.
//   KEY_COUNT    number of push-button lines in the bank
//   KEY_CODE_W   width of a key index (log2 of KEY_COUNT)
//   key_state_e  press/release machine states
package key_pkg;

    localparam int KEY_COUNT  = 8;
    localparam int KEY_CODE_W = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } key_state_e;

endpackage

// File: rtl/key_encoder_8_3_if.sv
// key_encoder_8_3_if: button bank in, encoded key events out.
//   keys_n       raw active-low buttons (asynchronous to clk)
//   key_code     index of the lowest-numbered debounced pressed key
//   key_valid    level, at least one debounced key pressed
//   key_press    one-cycle strobe, a new key_code became valid
//   key_release  one-cycle strobe, all keys released
//   key_multi    level, two or more debounced keys pressed
// master: the encoder; slave: the button bank / game control side.
interface key_encoder_8_3_if;
    import key_pkg::*;

    logic [KEY_COUNT-1:0]  keys_n;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_press;
    logic                  key_release;
    logic                  key_multi;

    modport master (
        input  keys_n,
        output key_code, key_valid, key_press, key_release, key_multi
    );

    modport slave (
        output keys_n,
        input  key_code, key_valid, key_press, key_release, key_multi
    );

endinterface

// File: rtl/debounce_line.sv
// debounce_line: two-flop synchroniser plus level debouncer for one
// active-low button line.
//   clk       system clock
//   rst       asynchronous active-high reset (line reads as released)
//   raw_n     raw active-low button, asynchronous to clk
//   stable_n  accepted (debounced) level, active-low
// A new level is accepted only after DEBOUNCE_CYCLES consecutive sampled
// cycles that disagree with the accepted level.
module debounce_line #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic stable_n
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            // Counter holds the number of disagreeing cycles already seen;
            // the DEBOUNCE_CYCLES-th one flips the accepted level.
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_n = stable_q;

endmodule

// File: rtl/key_encoder_8_3.sv
// key_encoder_8_3: debounced 8-to-3 encoder for the active-low button bank.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  key_encoder_8_3_if.master: keys_n in; key_code, key_valid,
//        key_press, key_release, key_multi out
// Each line is synchronised and debounced, a priority encoder picks the
// lowest pressed index, and a two-state machine turns level changes into
// press/release strobes. All outputs are registered.
module key_encoder_8_3
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    key_encoder_8_3_if.master         bus
);

    logic [KEY_COUNT-1:0]  stable_n;
    logic [KEY_COUNT-1:0]  pressed;
    logic [KEY_CODE_W-1:0] enc;
    logic [3:0]            pop;
    logic                  any;
    logic                  multi;

    key_state_e            state_q, state_d;
    logic [KEY_CODE_W-1:0] code_q, code_d;
    logic                  press_q, press_d;
    logic                  release_q, release_d;
    logic                  multi_q, multi_d;

    for (genvar g = 0; g < KEY_COUNT; g++) begin : g_line
        debounce_line #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_line (
            .clk      (clk),
            .rst      (rst),
            .raw_n    (bus.keys_n[g]),
            .stable_n (stable_n[g])
        );
    end

    // Priority encoder and popcount over the debounced levels.
    // Scanning downwards lets the lowest pressed index win.
    always_comb begin
        pressed = ~stable_n;
        enc     = '0;
        pop     = '0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (pressed[i]) begin
                enc = KEY_CODE_W'(i);
            end
        end
        for (int i = 0; i < KEY_COUNT; i++) begin
            pop = pop + {3'b000, pressed[i]};
        end
        any   = |pressed;
        multi = (pop >= 4'd2);
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        multi_d   = multi;
        unique case (state_q)
            S_IDLE: begin
                if (any) begin
                    state_d = S_HELD;
                    code_d  = enc;
                    press_d = 1'b1;
                end
            end
            S_HELD: begin
                if (!any) begin
                    // key_code keeps the last key so the consumer can
                    // still see what was released.
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                end else if (enc != code_q) begin
                    // Lower key added, or lowest key let go while
                    // others stay down: report the new lowest key.
                    code_d  = enc;
                    press_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            press_q   <= press_d;
            release_q <= release_d;
            multi_q   <= multi_d;
        end
    end

    assign bus.key_code    = code_q;
    assign bus.key_valid   = (state_q == S_HELD);
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_multi   = multi_q;

endmodule

// File: tb/tb_key_encoder_8_3.sv
module tb_key_encoder_8_3;
    import key_pkg::*;

    localparam int DC  = 4;
    localparam int CW  = 3;
    localparam int LAT = DC + 3;

    typedef struct {
        logic [7:0] keys_n;
        logic       press;
        logic       rel;
        logic [2:0] code;
        logic       valid;
        logic       multi;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[8];
    vec_t v;

    always #5 clk = ~clk;

    key_encoder_8_3_if bus();

    key_encoder_8_3 #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_press"}, 32'(bus.key_press), 0);
        chk({tag, "_release"}, 32'(bus.key_release), 0);
    endtask

    task automatic chk_out(input string tag, input vec_t e);
        chk({tag, "_press"}, 32'(bus.key_press), 32'(e.press));
        chk({tag, "_release"}, 32'(bus.key_release), 32'(e.rel));
        chk({tag, "_code"}, 32'(bus.key_code), 32'(e.code));
        chk({tag, "_valid"}, 32'(bus.key_valid), 32'(e.valid));
        chk({tag, "_multi"}, 32'(bus.key_multi), 32'(e.multi));
    endtask

    // Drive a new level just after a falling edge, expect the strobe after
    // the LAT-th rising edge (the first one samples the new level), then a
    // quiet hold with outputs unchanged.
    task automatic apply(input vec_t e, input string tag);
        vec_t q;
        @(negedge clk);
        bus.keys_n = e.keys_n;
        for (int k = 1; k < LAT; k++) begin
            tick();
            chk_quiet({tag, "_early"});
        end
        tick();
        chk_out({tag, "_event"}, e);
        q = e;
        q.press = 1'b0;
        q.rel = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk_out({tag, "_hold"}, q);
        end
    endtask

    initial begin
        // keys_n, press, rel, code, valid, multi
        vecs[0] = '{8'hDF, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0};  // key 5 pressed
        vecs[1] = '{8'hFF, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0};  // released, code holds
        vecs[2] = '{8'hBF, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0};  // key 6 held
        vecs[3] = '{8'hBD, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1};  // key 1 added
        vecs[4] = '{8'hBF, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0};  // key 1 released
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0};  // key 6 released
        vecs[6] = '{8'h77, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1};  // keys 3+7 together
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};  // both released

        // Reset state and idle quietness
        bus.keys_n = 8'hFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        v = '{8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        chk_out("reset", v);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_out("post_reset", v);
        end

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Bounce on key 2: two cycles low, two high, three times over
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.keys_n = (((c / 2) % 2) == 0) ? 8'hFB : 8'hFF;
            tick();
            chk_quiet("bounce");
        end
        v = '{8'hFB, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        apply(v, "bounce_settle");
        v = '{8'hFF, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
        apply(v, "bounce_release");

        // Reset while HELD, key 4 kept down throughout
        v = '{8'hEF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
        apply(v, "k4_press");
        @(negedge clk);
        rst = 1'b1;
        #1;
        v = '{8'hEF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        chk_out("async_reset", v);
        repeat (3) @(posedge clk);
        #1;
        chk_out("in_reset", v);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            tick();
            chk_out("redetect_early", v);
        end
        tick();
        v = '{8'hEF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
        chk_out("redetect", v);
        tick();
        chk_quiet("redetect_after");
        v = '{8'hFF, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
        apply(v, "k4_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
